// File: rtl/resilient_delay_tuner_if.sv
// Token-source / stage bundle for the delay tuner; no logic.
// Latency: none (wires only).
// Backpressure: tok_ready and the sreq/sack 4-phase pair carry all flow control.
interface resilient_delay_tuner_if #(
  parameter int DCODE_W = 4,
  parameter int SCORE_W = 6
);
  logic               en;
  logic               tok_valid;
  logic               tok_ready;
  logic               sreq;
  logic               sack;
  logic               err0;
  logic               err1;
  logic [DCODE_W-1:0] dcode;
  logic               win_done;
  logic               dcode_sat;
  logic               stall;
  logic [SCORE_W-1:0] err_score;

  // tuner side
  modport master (
    input  en, tok_valid, sack, err0, err1,
    output tok_ready, sreq, dcode, win_done, dcode_sat, stall, err_score
  );

  // source/stage side
  modport slave (
    output en, tok_valid, sack, err0, err1,
    input  tok_ready, sreq, dcode, win_done, dcode_sat, stall, err_score
  );
endinterface

// File: rtl/resilient_delay_tuner.sv
// Issues one token at a time over 4-phase req/ack, scores stage error flags per window, steps the delay code.
// Latency: sreq rises the cycle after accept; win_done/dcode update the cycle after the window's last sample.
// Backpressure: tok_ready only in IDLE with en=1 and sack=0; a stuck REQ waits forever and raises sticky stall.
module resilient_delay_tuner #(
  parameter int DCODE_W   = 4,
  parameter int DCODE_RST = 8,
  parameter int WIN       = 16,
  parameter int HI_THR    = 2,
  parameter int LO_THR    = 0,
  parameter int TO_CYC    = 64
) (
  input  logic clk,
  input  logic rst,
  resilient_delay_tuner_if.master bus
);

  localparam int SCORE_W = $clog2(2*WIN+1);
  localparam int CNT_W   = $clog2(WIN);
  localparam int TO_W    = $clog2(TO_CYC+1);

  localparam logic [SCORE_W:0]   SCORE_MAX = (SCORE_W+1)'(2*WIN);
  localparam logic [SCORE_W:0]   HI        = (SCORE_W+1)'(HI_THR);
  localparam logic [SCORE_W:0]   LO        = (SCORE_W+1)'(LO_THR);
  localparam logic [DCODE_W-1:0] DCODE_TOP = '1;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t             state, state_nxt;
  logic [DCODE_W-1:0] dcode_q;
  logic [SCORE_W-1:0] score_q;
  logic [CNT_W-1:0]   tok_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               win_done_q;
  logic               dcode_sat_q;
  logic               stall_q;

  logic               sample;
  logic               win_end;
  logic [1:0]         weight;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W:0]   score_new;

  // State register; reset abandons any in-flight token and drops sreq immediately.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake outputs and the one-cycle sample strobe.
  always_comb begin
    state_nxt     = state;
    sample        = 1'b0;
    bus.tok_ready = 1'b0;
    bus.sreq      = (state == REQ);
    case (state)
      IDLE: begin
        // sack still high means the stage has not returned to zero yet
        bus.tok_ready = bus.en & ~bus.sack & ~rst;
        if (bus.tok_valid && bus.tok_ready) state_nxt = REQ;
      end
      REQ: begin
        if (bus.sack) begin
          sample    = 1'b1;
          state_nxt = REL;
        end
      end
      REL: begin
        if (!bus.sack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Weighted score including the token being sampled, saturated at 2*WIN.
  always_comb begin
    weight    = bus.err1 ? 2'd2 : (bus.err0 ? 2'd1 : 2'd0);
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(weight);
    score_new = (score_sum > SCORE_MAX) ? SCORE_MAX : score_sum;
    win_end   = sample && (tok_cnt == CNT_W'(WIN-1));
  end

  // Window accumulation and the end-of-window delay-code step.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcode_q     <= DCODE_W'(DCODE_RST);
      score_q     <= '0;
      tok_cnt     <= '0;
      win_done_q  <= 1'b0;
      dcode_sat_q <= 1'b0;
    end else begin
      win_done_q <= 1'b0;
      if (sample) begin
        if (win_end) begin
          win_done_q <= 1'b1;
          score_q    <= '0;
          tok_cnt    <= '0;
          if (score_new > HI) begin
            if (dcode_q == DCODE_TOP) dcode_sat_q <= 1'b1;
            else begin
              dcode_q     <= dcode_q + DCODE_W'(1);
              dcode_sat_q <= 1'b0;
            end
          end else if (score_new <= LO) begin
            if (dcode_q == '0) dcode_sat_q <= 1'b1;
            else begin
              dcode_q     <= dcode_q - DCODE_W'(1);
              dcode_sat_q <= 1'b0;
            end
          end else begin
            dcode_sat_q <= 1'b0;
          end
        end else begin
          score_q <= score_new[SCORE_W-1:0];
          tok_cnt <= tok_cnt + CNT_W'(1);
        end
      end
    end
  end

  // REQ timeout: counts REQ cycles without sack; stall sets on the edge the count reaches TO_CYC.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      stall_q <= 1'b0;
    end else if (state == REQ) begin
      if (!bus.sack) begin
        if (to_cnt != TO_W'(TO_CYC)) to_cnt <= to_cnt + TO_W'(1);
        if (to_cnt == TO_W'(TO_CYC-1)) stall_q <= 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end

  assign bus.dcode     = dcode_q;
  assign bus.err_score = score_q;
  assign bus.win_done  = win_done_q;
  assign bus.dcode_sat = dcode_sat_q;
  assign bus.stall     = stall_q;

endmodule

// File: tb/tb_resilient_delay_tuner.sv
// Directed bench for resilient_delay_tuner: stage modelled inline with a 2-cycle ack latency.
// Latency: checks sampled on the falling edge, inputs driven right after it.
// Backpressure: tok_ready and sreq/sack timing checked per token; stall checked with a held-off ack.
module tb_resilient_delay_tuner;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  resilient_delay_tuner_if #(.DCODE_W(4), .SCORE_W(6)) bus ();

  resilient_delay_tuner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full 4-phase token; starts and ends on a falling edge with the DUT in IDLE.
  task automatic run_token(input logic e0, input logic e1, input bit last,
                           input int exp_dc, input bit exp_sat, input int exp_score);
    bus.tok_valid = 1'b1;
    #1 chk("tok_ready_idle", bus.tok_ready, 1);
    @(negedge clk);
    bus.tok_valid = 1'b0;
    chk("sreq_rise", bus.sreq, 1);
    @(negedge clk);
    chk("sreq_hold", bus.sreq, 1);
    bus.sack = 1'b1;
    bus.err0 = e0;
    bus.err1 = e1;
    @(negedge clk);
    chk("sreq_fall", bus.sreq, 0);
    chk("win_done", bus.win_done, last);
    chk("dcode", bus.dcode, exp_dc);
    chk("err_score", bus.err_score, exp_score);
    if (last) chk("dcode_sat", bus.dcode_sat, exp_sat);
    // flags raised outside the sample cycle must not count
    bus.err0 = 1'b1;
    bus.err1 = 1'b1;
    #1 chk("tok_ready_rel", bus.tok_ready, 0);
    @(negedge clk);
    chk("win_done_pulse", bus.win_done, 0);
    bus.sack = 1'b0;
    bus.err0 = 1'b0;
    bus.err1 = 1'b0;
    @(negedge clk);
  endtask

  // 16 tokens; bit t of m0/m1 is token t+1's err0/err1.
  task automatic run_window(input logic [15:0] m0, input logic [15:0] m1,
                            input int dc0, input int dc1, input bit sat1);
    int sc = 0;
    for (int t = 0; t < 16; t++) begin
      int w;
      w  = m1[t] ? 2 : (m0[t] ? 1 : 0);
      sc = (sc + w > 32) ? 32 : sc + w;
      run_token(m0[t], m1[t], t == 15, (t == 15) ? dc1 : dc0, sat1, (t == 15) ? 0 : sc);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.en        = 1'b1;
    bus.tok_valid = 1'b0;
    bus.sack      = 1'b0;
    bus.err0      = 1'b0;
    bus.err1      = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // reset state
    chk("rst_sreq", bus.sreq, 0);
    chk("rst_tok_ready", bus.tok_ready, 0);
    chk("rst_dcode", bus.dcode, 8);
    chk("rst_score", bus.err_score, 0);
    chk("rst_win_done", bus.win_done, 0);
    chk("rst_dcode_sat", bus.dcode_sat, 0);
    chk("rst_stall", bus.stall, 0);
    rst = 1'b0;
    #1 chk("post_rst_ready", bus.tok_ready, 1);

    // en=0 blocks acceptance
    bus.en        = 1'b0;
    bus.tok_valid = 1'b1;
    #1 chk("en0_ready", bus.tok_ready, 0);
    @(negedge clk);
    chk("en0_no_req", bus.sreq, 0);
    bus.tok_valid = 1'b0;
    bus.en        = 1'b1;

    // clean window: 8 -> 7
    run_window(16'h0000, 16'h0000, 8, 7, 0);

    // err1 on tokens 3 and 9 (score 4): 8 -> 9
    do_reset();
    run_window(16'h0000, 16'h0104, 8, 9, 0);

    // err0 on token 5 only (score 1): hold at 8
    do_reset();
    run_window(16'h0010, 16'h0000, 8, 8, 0);

    // climb to 15, saturate, then step down
    for (int k = 0; k < 7; k++) run_window(16'h0000, 16'hFFFF, 8 + k, 9 + k, 0);
    run_window(16'h0000, 16'hFFFF, 15, 15, 1);
    run_window(16'h0000, 16'h0000, 15, 14, 0);

    // reset mid-window while REQ has sack=1
    run_token(1'b0, 1'b1, 1'b0, 14, 1'b0, 2);
    run_token(1'b0, 1'b1, 1'b0, 14, 1'b0, 4);
    run_token(1'b0, 1'b1, 1'b0, 14, 1'b0, 6);
    bus.tok_valid = 1'b1;
    @(negedge clk);
    bus.tok_valid = 1'b0;
    chk("t6_sreq", bus.sreq, 1);
    bus.sack = 1'b1;
    rst      = 1'b1;
    #1 chk("t6_rst_ready", bus.tok_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_sreq_drop", bus.sreq, 0);
    chk("t6_dcode", bus.dcode, 8);
    chk("t6_score", bus.err_score, 0);
    chk("t6_ready_blocked", bus.tok_ready, 0);
    bus.tok_valid = 1'b1;
    @(negedge clk);
    chk("t6_no_accept", bus.sreq, 0);
    bus.sack = 1'b0;
    #1 chk("t6_ready_after_rtz", bus.tok_ready, 1);
    @(negedge clk);
    bus.tok_valid = 1'b0;
    chk("t6_accept", bus.sreq, 1);
    bus.sack = 1'b1;
    @(negedge clk);
    chk("t6_sreq_fall", bus.sreq, 0);
    bus.sack = 1'b0;
    @(negedge clk);

    // REQ timeout with ack held off
    bus.tok_valid = 1'b1;
    #1 chk("t5_ready", bus.tok_ready, 1);
    @(negedge clk);
    bus.tok_valid = 1'b0;
    repeat (63) @(negedge clk);
    chk("t5_stall_63", bus.stall, 0);
    chk("t5_sreq_63", bus.sreq, 1);
    @(negedge clk);
    chk("t5_stall_64", bus.stall, 1);
    chk("t5_sreq_64", bus.sreq, 1);
    repeat (5) @(negedge clk);
    chk("t5_sreq_held", bus.sreq, 1);
    bus.sack = 1'b1;
    bus.err1 = 1'b1;
    @(negedge clk);
    chk("t5_sreq_fall", bus.sreq, 0);
    chk("t5_score", bus.err_score, 2);
    bus.err1 = 1'b0;
    bus.sack = 1'b0;
    @(negedge clk);
    chk("t5_stall_sticky", bus.stall, 1);
    chk("t5_idle_ready", bus.tok_ready, 1);
    do_reset();
    chk("t5_stall_clear", bus.stall, 0);
    chk("t5_score_clear", bus.err_score, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
